// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row-by-row scan, whole-scan debounce and a
// 4-entry first-word-fall-through FIFO of debounced key presses.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic [3:0] key_code,
    output logic       empty,
    output logic       key_down,
    output logic       overflow
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        ACCUM = 2'd2
    } scan_state_t;

    // Returns {hit, col} for the lowest-index low column of an active-low sample.
    function automatic logic [2:0] first_low_col(input logic [3:0] c);
        logic [2:0] r;
        if (!c[0]) begin
            r = 3'b100;
        end else if (!c[1]) begin
            r = 3'b101;
        end else if (!c[2]) begin
            r = 3'b110;
        end else if (!c[3]) begin
            r = 3'b111;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // synchronizer
    logic [3:0]    cols_meta_r, cols_sync_r;
    // scan FSM
    scan_state_t   state_r, state_n;
    logic [1:0]    row_r, row_n;
    logic [CW-1:0] settle_r, settle_n;
    logic [3:0]    rows_r, rows_n;
    logic          sample_s;
    logic [2:0]    col_hit_s;
    // per-scan candidate
    logic          cand_hit_r, cand_hit_n;
    logic [3:0]    cand_code_r, cand_code_n;
    // debounce
    logic          prev_hit_r, prev_hit_n;
    logic [3:0]    prev_code_r, prev_code_n;
    logic [SW-1:0] stable_r, stable_n;
    logic          deb_hit_r, deb_hit_n;
    logic [3:0]    deb_code_r, deb_code_n;
    logic          push_s;
    // FIFO
    logic [3:0]    mem_r [4];
    logic [1:0]    wr_ptr_r, wr_ptr_n;
    logic [1:0]    rd_ptr_r, rd_ptr_n;
    logic [1:0]    rd_next_s;
    logic [2:0]    count_r, count_n;
    logic          pop_s, full_s, wr_s, drop_s;
    logic [3:0]    key_code_r, key_code_n;
    logic          empty_r;
    logic          overflow_r, overflow_n;

    assign rows     = rows_r;
    assign key_code = key_code_r;
    assign empty    = empty_r;
    assign key_down = deb_hit_r;
    assign overflow = overflow_r;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_meta_r <= 4'b1111;
            cols_sync_r <= 4'b1111;
        end else begin
            cols_meta_r <= cols;
            cols_sync_r <= cols_meta_r;
        end
    end

    // Scan next-state: row sequencing, settle counting and the row drive for next cycle.
    always_comb begin
        state_n  = state_r;
        row_n    = row_r;
        settle_n = settle_r;
        sample_s = 1'b0;
        rows_n   = 4'b1111;
        case (state_r)
            IDLE: begin
                state_n  = DRIVE;
                row_n    = 2'd0;
                settle_n = '0;
            end
            DRIVE: begin
                if (settle_r == SETTLE_LAST) begin
                    sample_s = 1'b1;
                    settle_n = '0;
                    row_n    = row_r + 2'd1;
                    if (row_r == 2'd3) begin
                        state_n = ACCUM;
                    end else begin
                        state_n = DRIVE;
                    end
                end else begin
                    settle_n = settle_r + CW'(1);
                end
            end
            ACCUM: begin
                state_n  = DRIVE;
                row_n    = 2'd0;
                settle_n = '0;
            end
            default: begin
                state_n  = IDLE;
                row_n    = 2'd0;
                settle_n = '0;
            end
        endcase
        // ACCUM keeps row 0 driven so the next scan's settle time starts early
        case (state_n)
            IDLE:    rows_n = 4'b1111;
            DRIVE:   rows_n = ~(4'b0001 << row_n);
            ACCUM:   rows_n = 4'b1110;
            default: rows_n = 4'b1111;
        endcase
    end

    // Scan state register with registered row drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            row_r    <= 2'd0;
            settle_r <= '0;
            rows_r   <= 4'b1111;
        end else begin
            state_r  <= state_n;
            row_r    <= row_n;
            settle_r <= settle_n;
            rows_r   <= rows_n;
        end
    end

    // Latch the first hit of a scan (lowest code); cleared once ACCUM consumes it.
    always_comb begin
        col_hit_s   = first_low_col(cols_sync_r);
        cand_hit_n  = cand_hit_r;
        cand_code_n = cand_code_r;
        if (state_r == ACCUM) begin
            cand_hit_n  = 1'b0;
            cand_code_n = 4'd0;
        end else if (sample_s && col_hit_s[2] && !cand_hit_r) begin
            cand_hit_n  = 1'b1;
            cand_code_n = {row_r, col_hit_s[1:0]};
        end else begin
            cand_hit_n  = cand_hit_r;
            cand_code_n = cand_code_r;
        end
    end

    // Debounce across whole scans and flag a press when the debounced key becomes a new hit.
    always_comb begin
        prev_hit_n  = prev_hit_r;
        prev_code_n = prev_code_r;
        stable_n    = stable_r;
        deb_hit_n   = deb_hit_r;
        deb_code_n  = deb_code_r;
        push_s      = 1'b0;
        if (state_r == ACCUM) begin
            if ({cand_hit_r, cand_code_r} == {prev_hit_r, prev_code_r}) begin
                if (stable_r == STABLE_MAX) begin
                    stable_n = stable_r;
                end else begin
                    stable_n = stable_r + SW'(1);
                end
            end else begin
                stable_n    = SW'(1);
                prev_hit_n  = cand_hit_r;
                prev_code_n = cand_code_r;
            end
            if ((stable_n == STABLE_MAX) &&
                ({cand_hit_r, cand_code_r} != {deb_hit_r, deb_code_r})) begin
                deb_hit_n  = cand_hit_r;
                deb_code_n = cand_code_r;
                push_s     = cand_hit_r;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Candidate and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_hit_r  <= 1'b0;
            cand_code_r <= 4'd0;
            prev_hit_r  <= 1'b0;
            prev_code_r <= 4'd0;
            stable_r    <= '0;
            deb_hit_r   <= 1'b0;
            deb_code_r  <= 4'd0;
        end else begin
            cand_hit_r  <= cand_hit_n;
            cand_code_r <= cand_code_n;
            prev_hit_r  <= prev_hit_n;
            prev_code_r <= prev_code_n;
            stable_r    <= stable_n;
            deb_hit_r   <= deb_hit_n;
            deb_code_r  <= deb_code_n;
        end
    end

    // FIFO control: push/pop arbitration, overflow and the registered head.
    always_comb begin
        pop_s      = rd_en && (count_r != 3'd0);
        full_s     = (count_r == 3'd4);
        wr_s       = push_s && (!full_s || pop_s);
        drop_s     = push_s && full_s && !pop_s;
        rd_next_s  = rd_ptr_r + 2'd1;
        wr_ptr_n   = wr_s  ? (wr_ptr_r + 2'd1) : wr_ptr_r;
        rd_ptr_n   = pop_s ? rd_next_s : rd_ptr_r;
        case ({wr_s, pop_s})
            2'b10:   count_n = count_r + 3'd1;
            2'b01:   count_n = count_r - 3'd1;
            default: count_n = count_r;
        endcase
        key_code_n = key_code_r;
        if (pop_s) begin
            if (count_r > 3'd1) begin
                key_code_n = mem_r[rd_next_s];
            end else if (wr_s) begin
                key_code_n = cand_code_r;
            end else begin
                key_code_n = key_code_r;
            end
        end else if (wr_s && (count_r == 3'd0)) begin
            key_code_n = cand_code_r;
        end else begin
            key_code_n = key_code_r;
        end
        // a dropped press takes priority over a simultaneous clear
        if (drop_s) begin
            overflow_n = 1'b1;
        end else if (ovf_clr) begin
            overflow_n = 1'b0;
        end else begin
            overflow_n = overflow_r;
        end
    end

    // FIFO storage, pointers, count and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 4'd0;
            end
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            count_r    <= 3'd0;
            key_code_r <= 4'd0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= cand_code_r;
            end
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            count_r    <= count_n;
            key_code_r <= key_code_n;
            empty_r    <= (count_n == 3'd0);
            overflow_r <= overflow_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural keypad matrix.
module tb_keypad_scanner;

    localparam int PERIOD = 17;   // 4*SETTLE_CYCLES + 1

    logic        clk = 1'b0;
    logic        rst, rd_en, ovf_clr;
    logic [3:0]  rows, cols, key_code;
    logic        empty, key_down, overflow;
    logic [15:0] key_mask;
    int          n_checks = 0;
    int          n_fail   = 0;

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst(rst), .rows(rows), .cols(cols), .rd_en(rd_en),
        .ovf_clr(ovf_clr), .key_code(key_code), .empty(empty),
        .key_down(key_down), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        logic [3:0] low;
        low = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !rows[r]) low[c] = 1'b1;
            end
        end
        cols = ~low;
    end

    // Waits for the ACCUM cycle (rows 0111 -> 1110); returns at its negedge.
    task automatic wait_accum(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = rows;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && rows == 4'b1110) begin
                ok = 1'b1;
                break;
            end
            prev = rows;
        end
    endtask

    task automatic wait_key_down(input logic val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_down === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_release(input int code);
        bit ok;
        key_mask = 16'(16'h0001 << code);
        wait_key_down(1'b1, 4*PERIOD, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL press_%0d: key_down=%b required 1", code, key_down); end
        key_mask = 16'h0000;
        wait_key_down(1'b0, 4*PERIOD, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL release_%0d: key_down=%b required 0", code, key_down); end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0; key_mask = 16'h0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rows, key_code, empty, key_down, overflow} !== {4'b1111, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rows=%b code=%0d empty=%b down=%b ovf=%b required 1111/0/1/0/0",
                     rows, key_code, empty, key_down, overflow);
        end
        rst = 1'b0;
        n_checks++;
        if (rows !== 4'b1111) begin n_fail++; $display("FAIL reset_idle_rows: rows=%b required 1111", rows); end
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i < 4)       exp = 4'b1110;
            else if (i < 8)  exp = 4'b1101;
            else if (i < 12) exp = 4'b1011;
            else if (i < 16) exp = 4'b0111;
            else             exp = 4'b1110;
            n_checks++;
            if (rows !== exp) begin n_fail++; $display("FAIL scan_rows[%0d]: rows=%b required %b", i, rows, exp); end
        end
    endtask

    task automatic test_press();
        bit ok;
        key_mask = 16'h0200;   // row 2, col 1 -> code 9
        ok = 1'b0;
        for (int i = 0; i < 3*PERIOD+2; i++) begin
            @(negedge clk);
            if (empty === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL press_latency: empty=%b required 0 within bound", empty); end
        n_checks++;
        if (key_code !== 4'd9) begin n_fail++; $display("FAIL press_code: key_code=%0d required 9", key_code); end
        n_checks++;
        if (key_down !== 1'b1) begin n_fail++; $display("FAIL press_down: key_down=%b required 1", key_down); end
        repeat (2*PERIOD) @(negedge clk);
        key_mask = 16'h0000;
        wait_key_down(1'b0, 4*PERIOD, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL release_down: key_down=%b required 0", key_down); end
        repeat (PERIOD) @(negedge clk);
        pop_one();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL press_single_entry: empty=%b required 1", empty); end
    endtask

    task automatic test_bounce();
        bit ok;
        wait_accum(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bounce_align: accum not seen"); end
        for (int s = 0; s < 6; s++) begin
            key_mask = (s % 2 == 0) ? 16'h0200 : 16'h0000;
            n_checks++;
            if (key_down !== 1'b0) begin n_fail++; $display("FAIL bounce_down[%0d]: key_down=%b required 0", s, key_down); end
            repeat (PERIOD) @(negedge clk);
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL bounce_no_push: empty=%b required 1", empty); end
        key_mask = 16'h0200;
        repeat (2*PERIOD+2) @(negedge clk);
        n_checks++;
        if ({empty, key_code, key_down} !== {1'b0, 4'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL bounce_settled: empty=%b code=%0d down=%b required 0/9/1", empty, key_code, key_down);
        end
        key_mask = 16'h0000;
        repeat (3*PERIOD) @(negedge clk);
        pop_one();
        n_checks++;
        if ({empty, key_down} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bounce_single_push: empty=%b down=%b required 1/0", empty, key_down);
        end
    endtask

    task automatic test_overflow();
        int codes [5] = '{0, 5, 10, 15, 3};
        for (int i = 0; i < 5; i++) press_release(codes[i]);
        n_checks++;
        if ({overflow, empty} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b empty=%b required 1/0", overflow, empty);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (key_code !== 4'(codes[i])) begin
                n_fail++;
                $display("FAIL ovf_pop[%0d]: key_code=%0d required %0d", i, key_code, codes[i]);
            end
            pop_one();
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: empty=%b required 1", empty); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: overflow=%b required 0", overflow); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int fill [4] = '{1, 2, 4, 7};
        int exp  [4] = '{2, 4, 7, 8};
        for (int i = 0; i < 4; i++) press_release(fill[i]);
        wait_accum(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_align: accum not seen"); end
        key_mask = 16'h0100;   // code 8, pushed in the ACCUM of the second scan
        repeat (2*PERIOD) @(negedge clk);
        pop_one();
        n_checks++;
        if ({overflow, empty, key_code, key_down} !== {1'b0, 1'b0, 4'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_push_pop: ovf=%b empty=%b code=%0d down=%b required 0/0/2/1",
                     overflow, empty, key_code, key_down);
        end
        key_mask = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (key_code !== 4'(exp[i])) begin
                n_fail++;
                $display("FAIL b2b_pop[%0d]: key_code=%0d required %0d", i, key_code, exp[i]);
            end
            pop_one();
        end
        n_checks++;
        if ({empty, overflow} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_count: empty=%b ovf=%b required 1/0", empty, overflow);
        end
    endtask

    task automatic test_multi_reset();
        bit ok;
        repeat (3*PERIOD) @(negedge clk);
        key_mask = 16'h1040;   // codes 6 and 12
        wait_key_down(1'b1, 4*PERIOD, ok);
        n_checks++;
        if (!ok || key_code !== 4'd6 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_lowest: key_code=%0d empty=%b required 6/0", key_code, empty);
        end
        key_mask = 16'h2000;   // code 13, reset lands mid-debounce
        wait_accum(ok);
        repeat (PERIOD+3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rows, key_code, empty, key_down, overflow} !== {4'b1111, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_values: rows=%b code=%0d empty=%b down=%b ovf=%b required 1111/0/1/0/0",
                     rows, key_code, empty, key_down, overflow);
        end
        rst = 1'b0;
        key_mask = 16'h0000;
        n_checks++;
        if (rows !== 4'b1111) begin n_fail++; $display("FAIL midreset_idle: rows=%b required 1111", rows); end
        @(negedge clk);
        n_checks++;
        if (rows !== 4'b1110) begin n_fail++; $display("FAIL midreset_restart: rows=%b required 1110", rows); end
        repeat (3*PERIOD) @(negedge clk);
        n_checks++;
        if ({empty, key_down} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_discard: empty=%b down=%b required 1/0", empty, key_down);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_overflow();
        test_back_to_back();
        test_multi_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
